// File: rtl/vx_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQS clients.
// One-entry request buffer, read credit cap, tag-indexed response routing.
module vx_mem_req_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_SIZE   = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 16,
  localparam int IDX_W  = $clog2(NUM_REQS),
  localparam int TW_OUT = TAG_WIDTH + IDX_W,
  localparam int DW     = DATA_SIZE * 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS-1:0]            req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQS*DW-1:0]         req_data,
  input  logic [NUM_REQS*DATA_SIZE-1:0]  req_byteen,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic [NUM_REQS-1:0]            rsp_valid,
  output logic [DW-1:0]                  rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic [NUM_REQS-1:0]            rsp_ready,
  output logic                           mem_req_valid,
  output logic                           mem_req_rw,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DW-1:0]                  mem_req_data,
  output logic [DATA_SIZE-1:0]           mem_req_byteen,
  output logic [TW_OUT-1:0]              mem_req_tag,
  input  logic                           mem_req_ready,
  input  logic                           mem_rsp_valid,
  input  logic [DW-1:0]                  mem_rsp_data,
  input  logic [TW_OUT-1:0]              mem_rsp_tag,
  output logic                           mem_rsp_ready,
  output logic                           busy
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic                  valid_q;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]         data_q;
  logic [DATA_SIZE-1:0]  byteen_q;
  logic [TW_OUT-1:0]     tag_q;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         pending_q, pending_d;

  logic                  can_accept;
  logic                  pending_ok;
  logic                  found;
  logic                  accept;
  logic                  read_acc;
  logic                  rsp_fire;
  logic                  idx_ok;
  logic [NUM_REQS-1:0]   elig;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      pos;
  logic [IDX_W-1:0]      rsp_idx;

  assign can_accept = !valid_q || mem_req_ready;
  assign pending_ok = pending_q < PW'(MAX_PENDING);
  assign elig = req_valid & (req_rw | {NUM_REQS{pending_ok}});

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    pos     = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      pos = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQS);
      if (!found && elig[pos]) begin
        found   = 1'b1;
        gnt_idx = pos;
      end
    end
  end

  // Ready stays low while reset is asserted, independent of clocking.
  assign accept    = reset && can_accept && found;
  assign req_ready = accept ? (NUM_REQS'(1) << gnt_idx) : '0;
  assign read_acc  = accept && !req_rw[gnt_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (gnt_idx == IDX_W'(NUM_REQS - 1)) rr_ptr_d = '0;
      else                                 rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    unique case ({read_acc, rsp_fire})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   if (pending_q != '0) pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      byteen_q  <= '0;
      tag_q     <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      if (accept) begin
        valid_q  <= 1'b1;
        rw_q     <= req_rw[gnt_idx];
        addr_q   <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        data_q   <= req_data[gnt_idx*DW +: DW];
        byteen_q <= req_byteen[gnt_idx*DATA_SIZE +: DATA_SIZE];
        tag_q    <= {req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH], gnt_idx};
      end else if (mem_req_ready) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign mem_req_valid  = valid_q;
  assign mem_req_rw     = rw_q;
  assign mem_req_addr   = addr_q;
  assign mem_req_data   = data_q;
  assign mem_req_byteen = byteen_q;
  assign mem_req_tag    = tag_q;
  assign busy           = valid_q || (pending_q != '0);

  // Out-of-range index: accept and drop so the bus never wedges.
  assign rsp_idx = mem_rsp_tag[IDX_W-1:0];
  always_comb begin
    idx_ok        = 1'b0;
    rsp_valid     = '0;
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == IDX_W'(i)) begin
        idx_ok        = 1'b1;
        rsp_valid[i]  = mem_rsp_valid;
        mem_rsp_ready = rsp_ready[i];
      end
    end
  end

  assign rsp_data = mem_rsp_data;
  assign rsp_tag  = mem_rsp_tag[TW_OUT-1:IDX_W];
  assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    rsp_fire |-> (pending_q != '0));
  a_rsp_idx_ok: assert property (@(posedge clk) disable iff (!reset)
    mem_rsp_valid |-> idx_ok);

endmodule

// File: tb/tb_vx_mem_req_arbiter.sv
// Directed bench for vx_mem_req_arbiter: vector table for
// round-robin grants plus sequences for stalls, credits and reset.
module tb_vx_mem_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DS = 64;
  localparam int DW = DS * 8;
  localparam int TW = 8;
  localparam int TO = TW + 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_rw;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*DS-1:0] req_byteen;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic [N-1:0]    rsp_ready;
  logic            mem_req_valid;
  logic            mem_req_rw;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_data;
  logic [DS-1:0]   mem_req_byteen;
  logic [TO-1:0]   mem_req_tag;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rsp_data;
  logic [TO-1:0]   mem_rsp_tag;
  logic            mem_rsp_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  vx_mem_req_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_byteen     (req_byteen),
    .req_tag        (req_tag),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .rsp_ready      (rsp_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] rw;
    logic       mrdy;
    logic [3:0] e_rdy;
    logic       e_mv;
    logic [1:0] e_idx;
    logic       e_rw;
    logic       e_busy;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TO-1:0] etag(input logic [1:0] i);
    logic [7:0] t;
    t = 8'h10 + {6'd0, i};
    return {t, i};
  endfunction

  function automatic logic [AW-1:0] eaddr(input logic [1:0] i);
    return 32'h1000 * ({30'd0, i} + 32'd1);
  endfunction

  task automatic rsp(input logic [7:0] t, input logic [1:0] i,
                     input logic [N-1:0] rdy);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {t, i};
    rsp_ready     = rdy;
  endtask

  initial begin
    reset         = 1'b0;
    req_valid     = 4'hF;
    req_rw        = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    rsp_ready     = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]   = eaddr(2'(i));
      req_data[i*DW +: DW]   = {8{64'hA5A5_0000_0000_0000 + 64'(i)}};
      req_byteen[i*DS +: DS] = {DS{1'b1}};
      req_tag[i*TW +: TW]    = 8'h10 + 8'(i);
    end

    //          v     rw   mrdy e_rdy mv idx rw busy
    vecs[0]  = '{4'hF, 4'h0, 1, 4'h1, 0, 0, 0, 0};
    vecs[1]  = '{4'hF, 4'h0, 1, 4'h2, 1, 0, 0, 1};
    vecs[2]  = '{4'hF, 4'h0, 1, 4'h4, 1, 1, 0, 1};
    vecs[3]  = '{4'hF, 4'h0, 1, 4'h8, 1, 2, 0, 1};
    vecs[4]  = '{4'hF, 4'h0, 1, 4'h1, 1, 3, 0, 1};
    vecs[5]  = '{4'h5, 4'h0, 1, 4'h4, 1, 0, 0, 1};
    vecs[6]  = '{4'h3, 4'h0, 1, 4'h1, 1, 2, 0, 1};
    vecs[7]  = '{4'h0, 4'h0, 1, 4'h0, 1, 0, 0, 1};
    vecs[8]  = '{4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 1};
    vecs[9]  = '{4'h8, 4'h8, 1, 4'h8, 0, 0, 0, 1};
    vecs[10] = '{4'h1, 4'h8, 0, 4'h0, 1, 3, 1, 1};
    vecs[11] = '{4'h1, 4'h8, 1, 4'h1, 1, 3, 1, 1};
    vecs[12] = '{4'h0, 4'h0, 1, 4'h0, 1, 0, 0, 1};

    // Reset state
    #3;
    chk("rst_mvalid", 64'(mem_req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Round-robin vector table (pending ends at 8, rr at 1)
    for (int i = 0; i < 13; i++) begin
      req_valid     = vecs[i].v;
      req_rw        = vecs[i].rw;
      mem_req_ready = vecs[i].mrdy;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_mvalid", i), 64'(mem_req_valid), 64'(vecs[i].e_mv));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d_tag", i), 64'(mem_req_tag), 64'(etag(vecs[i].e_idx)));
        chk($sformatf("v%0d_addr", i), 64'(mem_req_addr), 64'(eaddr(vecs[i].e_idx)));
        chk($sformatf("v%0d_rw", i), 64'(mem_req_rw), 64'(vecs[i].e_rw));
      end
      tick();
    end

    // Read accept and response in the same cycle: count unchanged (8)
    req_valid = 4'h1;
    req_rw    = 4'h0;
    rsp(8'h33, 2'd0, 4'hF);
    @(negedge clk);
    chk("same_ready", 64'(req_ready), 64'h1);
    chk("same_rspv", 64'(rsp_valid), 64'h1);
    chk("same_rtag", 64'(rsp_tag), 64'h33);
    tick();
    req_valid     = '0;
    mem_rsp_valid = 1'b0;
    tick();

    // Response to req3 held off by rsp_ready[3]
    mem_rsp_data = {8{64'hDEAD_BEEF_0123_4567}};
    for (int c = 0; c < 3; c++) begin
      rsp(8'h5A, 2'd3, 4'h7);
      @(negedge clk);
      chk("hold_rspv", 64'(rsp_valid), 64'h8);
      chk("hold_rtag", 64'(rsp_tag), 64'h5A);
      chk("hold_mrdy", 64'(mem_rsp_ready), 64'd0);
      chk("hold_data", rsp_data[63:0], 64'hDEAD_BEEF_0123_4567);
      tick();
    end
    rsp(8'h5A, 2'd3, 4'hF);
    @(negedge clk);
    chk("rel_mrdy", 64'(mem_rsp_ready), 64'd1);
    tick();

    // Six more responses leave one pending, the last clears busy
    for (int c = 0; c < 6; c++) begin
      rsp(8'(c), 2'(c), 4'hF);
      tick();
    end
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("busy_one_left", 64'(busy), 64'd1);
    tick();
    rsp(8'h77, 2'd2, 4'hF);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("busy_drained", 64'(busy), 64'd0);
    tick();

    // Fill the read credit with 16 reads from req1
    for (int c = 0; c < 16; c++) begin
      req_valid = 4'h2;
      req_rw    = 4'h0;
      @(negedge clk);
      chk($sformatf("fill%0d_ready", c), 64'(req_ready), 64'h2);
      tick();
    end
    @(negedge clk);
    chk("full_read_stall", 64'(req_ready), 64'h0);
    tick();
    req_valid = 4'h6;
    req_rw    = 4'h4;
    @(negedge clk);
    chk("full_write_gnt", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'h2;
    req_rw    = 4'h0;
    rsp(8'h01, 2'd1, 4'hF);
    @(negedge clk);
    chk("full_rsp_cycle", 64'(req_ready), 64'h0);
    tick();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("full_resume", 64'(req_ready), 64'h2);
    tick();

    // Reset with a buffered request and credits outstanding
    req_valid = 4'hF;
    chk("pre_rst_mvalid", 64'(mem_req_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst2_mvalid", 64'(mem_req_valid), 64'd0);
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_gnt", 64'(req_ready), 64'h1);

    // Req1 accepted, then memory stalls for four cycles
    req_valid = 4'h2;
    #1;
    chk("stall_acc", 64'(req_ready), 64'h2);
    tick();
    req_addr[AW +: AW] = 32'hDEAD_0000;
    mem_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_mvalid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'h2000);
      chk("stall_tag", 64'(mem_req_tag), 64'(etag(2'd1)));
      chk("stall_ready", 64'(req_ready), 64'h0);
      tick();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("drain_addr", 64'(mem_req_addr), 64'h2000);
    chk("drain_b2b", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("next_addr", 64'(mem_req_addr), 64'hDEAD_0000);
    chk("next_mvalid", 64'(mem_req_valid), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
